// File: rtl/iter_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// iter_muldiv_unit_if
// Handshake and data bundle between the execute stage and the iterative
// multiply/divide unit.
//   start        request pulse from the pipeline
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B         operands (Read_Data1 and the ALU operand mux output R3)
//   busy         operation in progress, the pipeline stalls on it
//   done         one-cycle completion pulse
//   HI, LO       product halves or remainder/quotient
//   div_by_zero  last completed divide had a zero divisor
// master drives the request side, slave is the unit itself.
// ---------------------------------------------------------------------------
interface iter_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             div_by_zero;

    modport master (
        output start, op, A, B,
        input  busy, done, HI, LO, div_by_zero
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, HI, LO, div_by_zero
    );
endinterface

// File: rtl/iter_muldiv_unit.sv
// ---------------------------------------------------------------------------
// iter_muldiv_unit
// Multi-cycle integer multiply/divide unit sitting beside the ALU. Signed
// operations run on magnitudes and fix up the signs in a final cycle.
// One result bit is produced per clock: shift-add for multiply, restoring
// shift-subtract for divide.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, aborts any operation in flight
//   bus    iter_muldiv_unit_if.slave (start/op/A/B in, busy/done/HI/LO/
//          div_by_zero out)
// ---------------------------------------------------------------------------
module iter_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    iter_muldiv_unit_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q;
    logic               isDiv_q;
    logic               negQuo_q;
    logic               negRem_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      count_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dbz_q;

    logic [WIDTH-1:0]   absA_d;
    logic [WIDTH-1:0]   absB_d;
    logic [WIDTH:0]     mulSum_d;
    logic [2*WIDTH-1:0] mulAcc_d;
    logic [WIDTH:0]     divPartial_d;
    logic [WIDTH:0]     divDiff_d;
    logic [2*WIDTH-1:0] divAcc_d;
    logic [2*WIDTH-1:0] fixProd_d;
    logic [WIDTH-1:0]   fixQuo_d;
    logic [WIDTH-1:0]   fixRem_d;

    // Operand magnitudes at request time, plus one iteration step of each
    // algorithm and the sign fix-up applied in the last cycle.
    // Multiply: acc holds {partial product, remaining multiplier bits};
    // opnd is the multiplicand. Divide: acc holds {remainder, dividend bits
    // being shifted out / quotient bits shifted in}; opnd is the divisor.
    always_comb begin
        absA_d = (bus.op[0] && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        absB_d = (bus.op[0] && bus.B[WIDTH-1]) ? -bus.B : bus.B;

        mulSum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mulAcc_d = {mulSum_d, acc_q[WIDTH-1:1]};

        // The partial remainder needs one extra bit because the shifted
        // remainder can exceed WIDTH bits before the subtract. A negative
        // difference (top bit set) means the divisor did not fit.
        divPartial_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        divDiff_d    = divPartial_d - {1'b0, opnd_q};
        if (!divDiff_d[WIDTH]) begin
            divAcc_d = {divDiff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            divAcc_d = {divPartial_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        fixProd_d = negQuo_q ? -acc_q : acc_q;
        fixQuo_d  = negQuo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        fixRem_d  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Control FSM and all result registers. A request is only accepted in
    // IDLE, so starts during busy or the done pulse are dropped, not queued.
    // A zero divisor skips the iterations and completes on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            isDiv_q  <= 1'b0;
            negQuo_q <= 1'b0;
            negRem_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        isDiv_q <= bus.op[1];
                        if (bus.op[1] && (bus.B == '0)) begin
                            hi_q    <= bus.A;
                            lo_q    <= '1;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            negQuo_q <= bus.op[0] & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            negRem_q <= bus.op[0] & bus.A[WIDTH-1];
                            if (bus.op[1]) begin
                                opnd_q <= absB_d;
                                acc_q  <= {{WIDTH{1'b0}}, absA_d};
                            end else begin
                                opnd_q <= absA_d;
                                acc_q  <= {{WIDTH{1'b0}}, absB_d};
                            end
                            count_q <= CW'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q   <= isDiv_q ? divAcc_d : mulAcc_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (isDiv_q) begin
                        hi_q <= fixRem_d;
                        lo_q <= fixQuo_d;
                    end else begin
                        hi_q <= fixProd_d[2*WIDTH-1:WIDTH];
                        lo_q <= fixProd_d[WIDTH-1:0];
                    end
                    dbz_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.HI          = hi_q;
    assign bus.LO          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_iter_muldiv_unit
// Self-checking bench for iter_muldiv_unit: a table of directed operations
// with hand-computed HI/LO/div_by_zero, latency and busy length, followed by
// hand-written sequences for ignored starts, mid-operation operand changes
// and an asynchronous reset during an operation.
// ---------------------------------------------------------------------------
module tb_iter_muldiv_unit;

    localparam int W = 32;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
        logic         expDbz;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[14];

    iter_muldiv_unit_if #(.WIDTH(W)) bus ();

    iter_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Safety net in case the handshake wedges somewhere unexpected.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Presents one request for a single cycle; returns 1 unit after the
    // edge that sampled it.
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges (from the cycle the request was raised) until done,
    // along with how many sampled cycles had busy set. Bounded.
    task automatic waitDone(input int startCount, output int lat, output int busyCycles);
        lat = startCount;
        busyCycles = 0;
        while (!bus.done && lat < 60) begin
            if (bus.busy) busyCycles++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runVector(input string name, input logic [1:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                             input logic expDbz);
        int lat;
        int busyCycles;
        applyStimulus(op, a, b);
        waitDone(1, lat, busyCycles);
        checkOutput({name, " HI"}, bus.HI, expHi);
        checkOutput({name, " LO"}, bus.LO, expLo);
        checkOutput({name, " div_by_zero"}, 32'(bus.div_by_zero), 32'(expDbz));
        checkOutput({name, " latency"}, 32'(lat), expDbz ? 32'd1 : 32'd34);
        checkOutput({name, " busy cycles"}, 32'(busyCycles), expDbz ? 32'd0 : 32'd33);
        @(posedge clk);
        #1;
        checkOutput({name, " done/busy after pulse"}, 32'({bus.done, bus.busy}), 32'd0);
    endtask

    initial begin
        int  lat;
        int  busyCycles;
        bit  sawDone;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[5]  = '{2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{2'b00, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0};
        vecs[7]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[8]  = '{2'b01, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
        vecs[9]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 1'b0};
        vecs[11] = '{2'b11, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vecs[12] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[13] = '{2'b11, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0};

        // Reset values while rst_n is held low.
        #3;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset HI", bus.HI, 32'd0);
        checkOutput("reset LO", bus.LO, 32'd0);
        checkOutput("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].expHi, vecs[i].expLo, vecs[i].expDbz);
        end

        // A second start inside CALC and operand changes afterwards must not
        // disturb the running MULTU 6*7.
        applyStimulus(2'b00, 32'd6, 32'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.A     = 32'd1000;
        bus.B     = 32'd1000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 32'hDEADBEEF;
        bus.B     = 32'h12345678;
        waitDone(6, lat, busyCycles);
        checkOutput("ignored start latency", 32'(lat), 32'd34);
        checkOutput("ignored start HI", bus.HI, 32'd0);
        checkOutput("ignored start LO", bus.LO, 32'd42);

        // A start raised during the done pulse is dropped as well.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.A     = 32'd3;
        bus.B     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("start during done busy", 32'(bus.busy), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("start during done not queued", 32'({bus.busy, bus.done}), 32'd0);
        checkOutput("start during done LO held", bus.LO, 32'd42);

        // Reset in CALC cycle 10 clears everything immediately and no late
        // done pulse appears.
        applyStimulus(2'b00, 32'd5, 32'd5);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre-reset busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkOutput("abort HI", bus.HI, 32'd0);
        checkOutput("abort LO", bus.LO, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) sawDone = 1'b1;
        end
        checkOutput("no done after abort", 32'(sawDone), 32'd0);
        runVector("post-reset MULTU", 2'b00, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
